div_issue_seq: RTL

Front-end sequencer for the sequential restoring divider. It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. It launches one divide at a time with a single-cycle start pulse, captures the quotient and remainder after the divider's fixed latency, and presents them on a valid/ready result port. Divide-by-zero is trapped locally; those operands never reach the divider.

---
 rtl/div_pkg.sv | 17 +
 rtl/op_fifo.sv | 42 ++++
 rtl/div_issue_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider issue sequencer: default widths,
// FSM states and the divide-by-zero quotient fill.
package div_pkg;

  localparam int N_W = 8;
  localparam int P_W = 8;

  // Every quotient bit is set when the divisor is zero.
  localparam logic DBZ_QUOTIENT_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/op_fifo.sv
// Operand FIFO: DEPTH entries of W bits, show-ahead head, extra pointer bit
// distinguishes full from empty.
module op_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/div_issue_seq.sv
// Front-end sequencer for the restoring divider: buffers operand pairs, issues
// one divide at a time, traps divide-by-zero locally, holds results for the consumer.
module div_issue_seq
  import div_pkg::*;
#(
  parameter int N     = N_W,
  parameter int P     = P_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_y,
  output logic         div_start,
  output logic [N-1:0] div_x,
  output logic [N-1:0] div_y,
  input  logic [P-1:0] div_quotient,
  input  logic [P-1:0] div_remainder,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_quotient,
  output logic [P-1:0] out_remainder,
  output logic         out_dbz,
  output logic         busy
);

  localparam int CW = $clog2(P + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            push, pop, full, empty;
  logic [2*N-1:0]  head;
  logic [N-1:0]    head_x, head_y;
  logic            slot_free, head_dbz, dbz_load, issue_load, capture;

  op_fifo #(.W(2 * N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .data  ({in_x, in_y}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign {head_x, head_y} = head;
  assign head_dbz   = (head_y == '0);
  assign slot_free  = !out_valid || out_ready;
  assign dbz_load   = pop && head_dbz;
  assign issue_load = pop && !head_dbz;
  assign capture    = (state == WAIT) && (cnt == CW'(P));
  assign busy       = (state != IDLE) || !empty;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    div_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && slot_free) begin
          pop = 1'b1;
          if (!head_dbz) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == CW'(P)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      div_x <= '0;
      div_y <= '0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (issue_load) begin
        div_x <= head_x;
        div_y <= head_y;
      end
    end
  end

  // Result slot: a new load wins over a same-edge drain, so results can run back-to-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dbz       <= 1'b0;
    end else if (dbz_load) begin
      out_valid     <= 1'b1;
      out_quotient  <= {P{DBZ_QUOTIENT_BIT}};
      out_remainder <= P'(head_x);
      out_dbz       <= 1'b1;
    end else if (capture) begin
      out_valid     <= 1'b1;
      out_quotient  <= div_quotient;
      out_remainder <= div_remainder;
      out_dbz       <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule
